// File: rtl/screen_write_buffer.sv
// Posted-write FIFO between the CPU screen region and the Screen VRAM port.
// Define SCREEN_WRITE_MERGE_EN to fold repeat writes into the tail entry.
module screen_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_write,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_stall,
  output logic              vram_load,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  input  logic              vram_busy,
  input  logic [DATA_W-1:0] vram_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    ADDR,
    DATA
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [PW:0]       count_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              req_wr;
  logic              wr_blk;
  logic              wr_ok;
  logic              merge;
  logic              full;
  logic              push;
  logic              pop;

  // The write of a combined read+write request is pushed once, in the
  // request cycle; it is still presented in the completion cycle.
  assign wr_blk = rd_done & req_wr;
  assign wr_ok  = (state == IDLE) & cpu_write & ~wr_blk;
  assign full   = (count == FULL);

`ifdef SCREEN_WRITE_MERGE_EN
  logic [PW-1:0] tail;

  assign tail  = wr_ptr - PW'(1);
  assign merge = wr_ok
               & (count >= (PW+1)'(2))
               & (addr_q[tail] == cpu_addr);
`else
  assign merge = 1'b0;
`endif

  assign vram_load = (count != '0)
                   & ((state == IDLE) | (state == DRAIN));
  assign pop       = vram_load & ~vram_busy;
  assign push      = wr_ok & ~merge & (~full | pop);
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);

  assign vram_addr = (state == ADDR) ? rd_addr : addr_q[rd_ptr];
  assign vram_din  = data_q[rd_ptr];

  assign cpu_stall = (state != IDLE)
                   | (cpu_read & ~rd_done)
                   | (wr_ok & ~merge & full & ~pop);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= cpu_addr;
      data_q[wr_ptr] <= cpu_din;
    end
`ifdef SCREEN_WRITE_MERGE_EN
    if (merge) begin
      data_q[tail] <= cpu_din;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rd_addr  <= '0;
      rd_done  <= 1'b0;
      req_wr   <= 1'b0;
      cpu_dout <= '0;
    end else begin
      count <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (state)
        IDLE: begin
          rd_done <= 1'b0;
          if (rd_done) begin
            req_wr <= 1'b0;
          end else if (cpu_read) begin
            rd_addr <= cpu_addr;
            req_wr  <= push;
            state   <= ((count != '0) | push) ? DRAIN : ADDR;
          end
        end
        DRAIN: begin
          if (count_nxt == '0) begin
            state <= ADDR;
          end
        end
        ADDR: begin
          if (!vram_busy) begin
            state <= DATA;
          end
        end
        DATA: begin
          cpu_dout <= vram_dout;
          rd_done  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_write_buffer.sv
// Bench for screen_write_buffer: VRAM model, drain scoreboard, read table.
// Build with SCREEN_WRITE_MERGE_EN defined to cover tail merging.
module tb_screen_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 13;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_write;
  logic          cpu_read;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_stall;
  logic          vram_load;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_din;
  logic          vram_busy;
  logic [DW-1:0] vram_dout;

  always #5 clk = ~clk;

  screen_write_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_write(cpu_write),
    .cpu_read (cpu_read),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_stall(cpu_stall),
    .vram_load(vram_load),
    .vram_addr(vram_addr),
    .vram_din (vram_din),
    .vram_busy(vram_busy),
    .vram_dout(vram_dout)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic          do_wr;
    logic          both;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
    int            lat;
  } vec_t;

  wr_t           exp_q[$];
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_nxt;
  vec_t          vt [8];
  int            n_vec;
  int            n_err;
  int            n_acc;
  int            occ;
  int            max_occ;
  bit            track;
  bit            rnd_busy;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (rnd_busy) vram_busy = 1'($urandom_range(0, 1));
  endtask

  task automatic cpu_wr(input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd,
                        input bit merge_tail,
                        input bit rel,
                        output bit st0);
    int  n;
    wr_t t;
    n   = 0;
    st0 = 1'b0;
    if (merge_tail) begin
      t = exp_q[exp_q.size()-1];
      t.d = wd;
      exp_q[exp_q.size()-1] = t;
    end else begin
      exp_q.push_back('{a: wa, d: wd});
    end
    cpu_write = 1'b1;
    cpu_addr  = wa;
    cpu_din   = wd;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      if (n == 0) st0 = 1'b1;
      n++;
      if (n > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_timeout: addr %0h still stalled", wa);
        break;
      end
      tick;
      if (rel) vram_busy = 1'b0;
    end
    tick;
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input vec_t v);
    int n;
    n = 0;
    if (v.both) exp_q.push_back('{a: v.wa, d: v.wd});
    cpu_read  = 1'b1;
    cpu_write = v.both;
    cpu_addr  = v.ra;
    cpu_din   = v.wd;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_timeout: addr %0h still stalled", v.ra);
        break;
      end
      tick;
    end
    check("rd_data", cpu_dout, v.exp);
    check("rd_order", exp_q.size(), 0);
    if (v.lat != 0) check("rd_latency", n, v.lat);
    tick;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick;
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    tick;
  endtask

  task automatic run_all;
    bit   st;
    int   acc0;
    logic pat [3];

    pat[0] = 1'b1;
    pat[1] = 1'b1;
    pat[2] = 1'b0;

    vt[0] = '{1'b1, 1'b0, 13'h1FFF, 16'h1234, 13'h1FFF, 16'h1234, 0};
    vt[1] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 13'h0001, 16'h5555, 3};
    vt[2] = '{1'b1, 1'b0, 13'h0002, 16'h7777, 13'h0002, 16'h7777, 0};
    vt[3] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 13'h0100, 16'hBEEF, 3};
    vt[4] = '{1'b1, 1'b0, 13'h0ABC, 16'hCAFE, 13'h0003, 16'h0F0F, 0};
    vt[5] = '{1'b0, 1'b1, 13'h0777, 16'h4321, 13'h0777, 16'h4321, 0};
    vt[6] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 13'h0ABC, 16'hCAFE, 3};
    vt[7] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 13'h0777, 16'h4321, 3};

    tick;
    tick;
    @(negedge clk);
    check("rst_stall", cpu_stall, 0);
    check("rst_load", vram_load, 0);
    check("rst_dout", cpu_dout, 0);
    tick;
    reset = 1'b0;

    // Burst into a busy Screen, fifth write hits full.
    acc0 = n_acc;
    vram_busy = 1'b1;
    cpu_wr(13'h0000, 16'hAAAA, 0, 0, st);
    check("burst_stall0", st, 0);
    cpu_wr(13'h0001, 16'h5555, 0, 0, st);
    check("burst_stall1", st, 0);
    cpu_wr(13'h0002, 16'hFFFF, 0, 0, st);
    check("burst_stall2", st, 0);
    cpu_wr(13'h0003, 16'h0F0F, 0, 0, st);
    check("burst_stall3", st, 0);
    cpu_wr(13'h0004, 16'h1111, 0, 1, st);
    check("full_stall", st, 1);
    wait_drain;
    check("burst_acc", n_acc - acc0, 5);

    // Head held stable while busy stretches.
    vram_busy = 1'b1;
    cpu_wr(13'h0100, 16'hBEEF, 0, 0, st);
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      vram_busy = pat[i];
      @(negedge clk);
      check("hold_load", vram_load, 1);
      check("hold_addr", vram_addr, 13'h0100);
      check("hold_din", vram_din, 16'hBEEF);
      tick;
    end
    @(negedge clk);
    check("hold_done", vram_load, 0);
    tick;
    check("hold_acc", n_acc - acc0, 1);
    wait_drain;

    for (int i = 0; i < 8; i++) begin
      if (vt[i].do_wr) cpu_wr(vt[i].wa, vt[i].wd, 0, 0, st);
      cpu_rd(vt[i]);
    end

    // Reset with queued writes discards them.
    acc0 = n_acc;
    vram_busy = 1'b1;
    cpu_wr(13'h0300, 16'h0001, 0, 0, st);
    cpu_wr(13'h0301, 16'h0002, 0, 0, st);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_load", vram_load, 0);
    check("mid_rst_stall", cpu_stall, 0);
    check("mid_rst_dout", cpu_dout, 0);
    tick;
    vram_busy = 1'b0;
    tick;
    tick;
    check("mid_rst_acc", n_acc - acc0, 0);

    // Wrap-around with sporadic busy.
    acc0 = n_acc;
    occ = 0;
    max_occ = 0;
    track = 1'b1;
    rnd_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_wr(AW'(13'h0200 + i), DW'($urandom), 0, 0, st);
    end
    wait_drain;
    rnd_busy = 1'b0;
    vram_busy = 1'b0;
    track = 1'b0;
    tick;
    check("wrap_acc", n_acc - acc0, 10);
    check("wrap_max_count", max_occ <= DEPTH, 1);

    acc0 = n_acc;
    vram_busy = 1'b1;
    cpu_wr(13'h0010, 16'h0001, 0, 0, st);
    cpu_wr(13'h0020, 16'h0002, 0, 0, st);
`ifdef SCREEN_WRITE_MERGE_EN
    cpu_wr(13'h0020, 16'h0003, 1, 0, st);
    check("merge_stall", st, 0);
    vram_busy = 1'b0;
    wait_drain;
    check("merge_acc", n_acc - acc0, 2);
`else
    cpu_wr(13'h0020, 16'h0003, 0, 0, st);
    check("nomerge_stall", st, 0);
    vram_busy = 1'b0;
    wait_drain;
    check("nomerge_acc", n_acc - acc0, 3);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    cpu_addr  = '0;
    cpu_din   = '0;
    vram_busy = 1'b0;
    vram_dout = '0;
    rd_nxt    = '0;
    n_vec     = 0;
    n_err     = 0;
    n_acc     = 0;
    occ       = 0;
    max_occ   = 0;
    track     = 1'b0;
    rnd_busy  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    fork
      begin : mon
        wr_t e;
        forever begin
          @(negedge clk);
          if (!reset && vram_load && !vram_busy) begin
            n_acc++;
            mem[vram_addr] = vram_din;
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_load: addr %0h data %0h, expected none",
                       vram_addr, vram_din);
            end else begin
              e = exp_q.pop_front();
              check("drain", {vram_addr, vram_din}, {e.a, e.d});
            end
          end
          if (track) begin
            occ = occ + int'(cpu_write && !cpu_stall)
                      - int'(vram_load && !vram_busy);
            if (occ > max_occ) max_occ = occ;
          end
          if (!vram_busy) rd_nxt = mem[vram_addr];
          @(posedge clk);
          vram_dout <= rd_nxt;
        end
      end
      begin : main
        run_all;
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
